// File: rtl/bus_compare_unit.sv
// Dual-channel bus comparator with a safety FSM that drives the relay and heartbeat outputs.
// Latency: the strobe edge captures the words, the next edge compares them, and the edge after that updates the state.
// Backpressure: none; every busValid strobe is accepted and the outputs are always driven.
module bus_compare_unit #(
  parameter int WIDTH          = 16,
  parameter int MISMATCH_LIMIT = 3,
  parameter int TOGGLE_DIV     = 4,
  parameter int TIMEOUT        = 255,
  parameter bit RELAY_POL      = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] busA,
  input  logic [WIDTH-1:0] busB,
  input  logic             busValid,
  input  logic             clrFault,
  output logic             relayCtrl,
  output logic             switchCtrl,
  output logic             fault,
  output logic [1:0]       faultCode,
  output logic [7:0]       mismatchTotal
);

  typedef enum logic [1:0] {IDLE, RUN, SUSPECT, FAULT} state_t;

  localparam logic [3:0] LIM    = 4'(MISMATCH_LIMIT);
  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);
  localparam logic [2:0] DIVMAX = 3'(TOGGLE_DIV - 1);

  logic [WIDTH-1:0] capA, capB;
  logic             capVld, cmpVld, cmpMis;
  state_t           state, stateNxt;
  logic [3:0]       misCnt, misCntNxt, misInc;
  logic [1:0]       codeNxt;
  logic [7:0]       idleCnt;
  logic [2:0]       divCnt;
  logic             misHit, matchHit, timeoutHit, activeNxt;

  // Capture stage on the strobe, then a registered compare one clock later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      capA   <= '0;
      capB   <= '0;
      capVld <= 1'b0;
      cmpVld <= 1'b0;
      cmpMis <= 1'b0;
    end else begin
      capVld <= busValid;
      if (busValid) begin
        capA <= busA;
        capB <= busB;
      end
      cmpVld <= capVld;
      cmpMis <= (capA != capB);
    end
  end

  assign misHit     = cmpVld && cmpMis;
  assign matchHit   = cmpVld && !cmpMis;
  assign misInc     = misCnt + 4'd1;
  assign timeoutHit = (idleCnt == TO_CNT);

  // Next-state decision; a mismatch reaching the limit outranks a timeout in the same cycle.
  always_comb begin
    stateNxt  = state;
    misCntNxt = misCnt;
    codeNxt   = faultCode;
    case (state)
      IDLE: begin
        if (misHit) begin
          misCntNxt = misInc;
          if (misInc >= LIM) begin
            stateNxt = FAULT;
            codeNxt  = 2'd1;
          end else begin
            stateNxt = SUSPECT;
          end
        end else if (matchHit) begin
          stateNxt = RUN;
        end
      end
      RUN, SUSPECT: begin
        if (misHit && (misInc >= LIM)) begin
          stateNxt  = FAULT;
          misCntNxt = misInc;
          codeNxt   = 2'd1;
        end else if (timeoutHit) begin
          stateNxt = FAULT;
          codeNxt  = 2'd2;
        end else if (misHit) begin
          stateNxt  = SUSPECT;
          misCntNxt = misInc;
        end else if (matchHit) begin
          stateNxt  = RUN;
          misCntNxt = 4'd0;
        end
      end
      FAULT: begin
        // Leaving FAULT drops any compare result landing in the same cycle.
        if (clrFault) begin
          stateNxt  = IDLE;
          misCntNxt = 4'd0;
          codeNxt   = 2'd0;
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  assign activeNxt = (stateNxt == RUN) || (stateNxt == SUSPECT);

  // State register, registered outputs, idle watchdog, heartbeat divider and mismatch tally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      misCnt        <= 4'd0;
      faultCode     <= 2'd0;
      fault         <= 1'b0;
      relayCtrl     <= ~RELAY_POL;
      idleCnt       <= 8'd0;
      divCnt        <= 3'd0;
      switchCtrl    <= 1'b0;
      mismatchTotal <= 8'd0;
    end else begin
      state     <= stateNxt;
      misCnt    <= misCntNxt;
      faultCode <= codeNxt;
      fault     <= (stateNxt == FAULT);
      relayCtrl <= activeNxt ? RELAY_POL : ~RELAY_POL;

      if ((state == FAULT) && clrFault) begin
        idleCnt <= 8'd0;
      end else if (busValid) begin
        idleCnt <= 8'd0;
      end else if (idleCnt != TO_CNT) begin
        idleCnt <= idleCnt + 8'd1;
      end

      // Divider is parked at zero in IDLE so a fresh RUN always starts a full half-period.
      if ((state == RUN) || (state == SUSPECT)) begin
        if (divCnt == DIVMAX) begin
          divCnt     <= 3'd0;
          switchCtrl <= ~switchCtrl;
        end else begin
          divCnt <= divCnt + 3'd1;
        end
      end else if (state == IDLE) begin
        divCnt <= 3'd0;
      end

      if (misHit && (mismatchTotal != 8'hFF)) begin
        mismatchTotal <= mismatchTotal + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_bus_compare_unit.sv
// Directed bench for bus_compare_unit with default parameters.
// Inputs change on the falling edge; outputs are checked on the falling edge.
// Each scenario task carries its own comparisons against hand-derived values.
module tb_bus_compare_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] busA = '0;
  logic [15:0] busB = '0;
  logic        busValid = 1'b0;
  logic        clrFault = 1'b0;
  logic        relayCtrl, switchCtrl, fault;
  logic [1:0]  faultCode;
  logic [7:0]  mismatchTotal;

  int nCmp = 0;
  int nMis = 0;
  int expTotal = 0;

  bus_compare_unit dut (
    .clk(clk), .rst(rst), .busA(busA), .busB(busB), .busValid(busValid),
    .clrFault(clrFault), .relayCtrl(relayCtrl), .switchCtrl(switchCtrl),
    .fault(fault), .faultCode(faultCode), .mismatchTotal(mismatchTotal)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle strobe; returns at the falling edge after the capturing rising edge.
  task automatic strobe(input logic [15:0] a, input logic [15:0] b);
    busA = a;
    busB = b;
    busValid = 1'b1;
    tick(1);
    busValid = 1'b0;
  endtask

  task automatic test_reset();
    tick(2);
    nCmp++; if (relayCtrl !== 1'b0) begin nMis++; $display("FAIL reset_relay: got %b want 0", relayCtrl); end
    nCmp++; if (switchCtrl !== 1'b0) begin nMis++; $display("FAIL reset_switch: got %b want 0", switchCtrl); end
    nCmp++; if (fault !== 1'b0) begin nMis++; $display("FAIL reset_fault: got %b want 0", fault); end
    nCmp++; if (faultCode !== 2'd0) begin nMis++; $display("FAIL reset_code: got %0d want 0", faultCode); end
    nCmp++; if (mismatchTotal !== 8'd0) begin nMis++; $display("FAIL reset_total: got %0d want 0", mismatchTotal); end
    rst = 1'b1;
    tick(2);
  endtask

  task automatic test_match_run();
    strobe(16'h1234, 16'h1234);
    tick(1);
    nCmp++; if (relayCtrl !== 1'b0) begin nMis++; $display("FAIL run_latency: relay got %b want 0", relayCtrl); end
    tick(1);
    nCmp++; if (relayCtrl !== 1'b1) begin nMis++; $display("FAIL run_relay: got %b want 1", relayCtrl); end
    nCmp++; if (switchCtrl !== 1'b0) begin nMis++; $display("FAIL run_switch0: got %b want 0", switchCtrl); end
    tick(3);
    nCmp++; if (switchCtrl !== 1'b0) begin nMis++; $display("FAIL run_switch3: got %b want 0", switchCtrl); end
    tick(1);
    nCmp++; if (switchCtrl !== 1'b1) begin nMis++; $display("FAIL run_switch4: got %b want 1", switchCtrl); end
    tick(3);
    nCmp++; if (switchCtrl !== 1'b1) begin nMis++; $display("FAIL run_switch7: got %b want 1", switchCtrl); end
    tick(1);
    nCmp++; if (switchCtrl !== 1'b0) begin nMis++; $display("FAIL run_switch8: got %b want 0", switchCtrl); end
  endtask

  task automatic test_mismatch_fault();
    logic sw0;
    strobe(16'h0001, 16'h0000);
    strobe(16'h0001, 16'h0000);
    strobe(16'h0001, 16'h0000);
    expTotal += 3;
    tick(1);
    nCmp++; if (fault !== 1'b0) begin nMis++; $display("FAIL mis_early_fault: got %b want 0", fault); end
    nCmp++; if (relayCtrl !== 1'b1) begin nMis++; $display("FAIL mis_suspect_relay: got %b want 1", relayCtrl); end
    tick(1);
    nCmp++; if (fault !== 1'b1) begin nMis++; $display("FAIL mis_fault: got %b want 1", fault); end
    nCmp++; if (faultCode !== 2'd1) begin nMis++; $display("FAIL mis_code: got %0d want 1", faultCode); end
    nCmp++; if (relayCtrl !== 1'b0) begin nMis++; $display("FAIL mis_relay: got %b want 0", relayCtrl); end
    nCmp++; if (mismatchTotal !== 8'(expTotal)) begin nMis++; $display("FAIL mis_total: got %0d want %0d", mismatchTotal, expTotal); end
    sw0 = switchCtrl;
    tick(9);
    nCmp++; if (switchCtrl !== sw0) begin nMis++; $display("FAIL mis_switch_frozen: got %b want %b", switchCtrl, sw0); end
    nCmp++; if (fault !== 1'b1) begin nMis++; $display("FAIL mis_latched: got %b want 1", fault); end
    clrFault = 1'b1;
    tick(1);
    clrFault = 1'b0;
    nCmp++; if (fault !== 1'b0) begin nMis++; $display("FAIL mis_clr_fault: got %b want 0", fault); end
    nCmp++; if (faultCode !== 2'd0) begin nMis++; $display("FAIL mis_clr_code: got %0d want 0", faultCode); end
    nCmp++; if (relayCtrl !== 1'b0) begin nMis++; $display("FAIL mis_clr_relay: got %b want 0", relayCtrl); end
  endtask

  task automatic test_recover();
    strobe(16'hABCD, 16'hABCD);
    tick(2);
    nCmp++; if (relayCtrl !== 1'b1) begin nMis++; $display("FAIL rec_run: got %b want 1", relayCtrl); end
    strobe(16'hFFFF, 16'h7FFF);
    strobe(16'h8000, 16'h0000);
    strobe(16'h5A5A, 16'h5A5A);
    expTotal += 2;
    tick(2);
    nCmp++; if (fault !== 1'b0) begin nMis++; $display("FAIL rec_fault: got %b want 0", fault); end
    nCmp++; if (relayCtrl !== 1'b1) begin nMis++; $display("FAIL rec_relay: got %b want 1", relayCtrl); end
    nCmp++; if (mismatchTotal !== 8'(expTotal)) begin nMis++; $display("FAIL rec_total: got %0d want %0d", mismatchTotal, expTotal); end
    // Counter must have cleared on the match, so two more mismatches stay short of the limit.
    strobe(16'h0010, 16'h0000);
    strobe(16'h0000, 16'h0100);
    strobe(16'h1111, 16'h1111);
    expTotal += 2;
    tick(2);
    nCmp++; if (fault !== 1'b0) begin nMis++; $display("FAIL rec_counter_clear: got %b want 0", fault); end
    clrFault = 1'b1;
    tick(1);
    clrFault = 1'b0;
    tick(1);
    nCmp++; if (relayCtrl !== 1'b1) begin nMis++; $display("FAIL rec_clr_ignored: got %b want 1", relayCtrl); end
  endtask

  task automatic test_timeout();
    strobe(16'h2222, 16'h2222);
    tick(254);
    nCmp++; if (fault !== 1'b0) begin nMis++; $display("FAIL to_early254: got %b want 0", fault); end
    tick(1);
    nCmp++; if (fault !== 1'b0) begin nMis++; $display("FAIL to_early255: got %b want 0", fault); end
    tick(1);
    nCmp++; if (fault !== 1'b1) begin nMis++; $display("FAIL to_fault: got %b want 1", fault); end
    nCmp++; if (faultCode !== 2'd2) begin nMis++; $display("FAIL to_code: got %0d want 2", faultCode); end
    clrFault = 1'b1;
    tick(1);
    clrFault = 1'b0;
    nCmp++; if (faultCode !== 2'd0) begin nMis++; $display("FAIL to_clr_code: got %0d want 0", faultCode); end
    nCmp++; if (mismatchTotal !== 8'(expTotal)) begin nMis++; $display("FAIL to_total: got %0d want %0d", mismatchTotal, expTotal); end
    tick(300);
    nCmp++; if (fault !== 1'b0) begin nMis++; $display("FAIL to_idle_nocheck: got %b want 0", fault); end
  endtask

  task automatic test_reset_mid();
    strobe(16'h3333, 16'h3333);
    tick(2);
    strobe(16'h0004, 16'h0000);
    tick(2);
    nCmp++; if (relayCtrl !== 1'b1) begin nMis++; $display("FAIL rm_suspect: got %b want 1", relayCtrl); end
    strobe(16'h0008, 16'h0000);
    rst = 1'b0;
    #1;
    nCmp++; if (relayCtrl !== 1'b0) begin nMis++; $display("FAIL rm_relay: got %b want 0", relayCtrl); end
    nCmp++; if (switchCtrl !== 1'b0) begin nMis++; $display("FAIL rm_switch: got %b want 0", switchCtrl); end
    nCmp++; if (mismatchTotal !== 8'd0) begin nMis++; $display("FAIL rm_total: got %0d want 0", mismatchTotal); end
    nCmp++; if ((fault !== 1'b0) || (faultCode !== 2'd0)) begin nMis++; $display("FAIL rm_fault: got %b/%0d want 0/0", fault, faultCode); end
    expTotal = 0;
    tick(3);
    rst = 1'b1;
    tick(3);
    nCmp++; if (mismatchTotal !== 8'd0) begin nMis++; $display("FAIL rm_discard: got %0d want 0", mismatchTotal); end
    strobe(16'h4444, 16'h4444);
    tick(2);
    nCmp++; if (relayCtrl !== 1'b1) begin nMis++; $display("FAIL rm_run: got %b want 1", relayCtrl); end
  endtask

  task automatic test_saturate();
    logic [15:0] a;
    logic [15:0] bit1;
    for (int i = 0; i < 300; i++) begin
      a = 16'(i * 37);
      bit1 = 16'd1 << (i % 16);
      strobe(a, a ^ bit1);
      strobe(a, a);
      if (expTotal < 255) expTotal++;
      if (i == 253) begin
        tick(2);
        nCmp++; if (mismatchTotal !== 8'd254) begin nMis++; $display("FAIL sat_254: got %0d want 254", mismatchTotal); end
      end
    end
    tick(2);
    nCmp++; if (mismatchTotal !== 8'(expTotal)) begin nMis++; $display("FAIL sat_255: got %0d want %0d", mismatchTotal, expTotal); end
    nCmp++; if (fault !== 1'b0) begin nMis++; $display("FAIL sat_fault: got %b want 0", fault); end
  endtask

  initial begin
    tick(1);
    test_reset();
    test_match_run();
    test_mismatch_fault();
    test_recover();
    test_timeout();
    test_reset_mid();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nMis);
    $finish;
  end

endmodule

// File: doc/bus_compare_unit.md
BUS_COMPARE_UNIT -- requirements
Module: bus_compare_unit

Interface
REQ-001 Parameter WIDTH, 16, compared bus width in bits.
REQ-002 Parameter MISMATCH_LIMIT, 3, consecutive mismatching compares that force FAULT (range 1..15).
REQ-003 Parameter TOGGLE_DIV, 4, heartbeat half-period in clocks (range 2..8).
REQ-004 Parameter TIMEOUT, 255, clocks without busValid that force FAULT (range 16..255).
REQ-005 Parameter RELAY_POL, 1, relayCtrl level while healthy; instances are paired with opposite RELAY_POL.
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 rst  input  1  reset; asynchronous, active-low.
REQ-008 busA  input  WIDTH  channel A bus word.
REQ-009 busB  input  WIDTH  channel B bus word.
REQ-010 busValid  input  1  single-cycle strobe; busA/busB valid in that cycle.
REQ-011 clrFault  input  1  request to leave FAULT.
REQ-012 relayCtrl  output  1  relay drive to the downstream output stage (XOR-paired).
REQ-013 switchCtrl  output  1  heartbeat toggle to the downstream output stage.
REQ-014 fault  output  1  high while in FAULT.
REQ-015 faultCode  output  2  cause: 0 none, 1 mismatch, 2 timeout.
REQ-016 mismatchTotal  output  8  saturating count of all mismatching compares.

Function
REQ-017 busA/busB SHALL be captured on the clk edge where busValid=1; comparison result SHALL be available one clock later (compare latency 2 clocks from strobe to state update).
REQ-018 Compare SHALL be bitwise equality over all WIDTH bits.
REQ-019 FSM states SHALL be IDLE, RUN, SUSPECT, FAULT.
REQ-020 IDLE: match -> RUN; mismatch -> SUSPECT (mismatch counter=1); no timeout check.
REQ-021 RUN: match -> RUN; mismatch -> SUSPECT, counter=1; idle counter reaching TIMEOUT -> FAULT, faultCode=2.
REQ-022 SUSPECT: match -> RUN, counter=0; mismatch -> counter+1; counter reaching MISMATCH_LIMIT -> FAULT, faultCode=1; timeout as RUN.
REQ-023 MISMATCH_LIMIT=1 SHALL send the first mismatch from IDLE/RUN directly to FAULT.
REQ-024 Idle counter SHALL clear on each busValid, increment otherwise, saturate at TIMEOUT.
REQ-025 Timeout and mismatch-limit in the same cycle SHALL give FAULT with faultCode=1.
REQ-026 FAULT is latched; clrFault=1 SHALL move to IDLE next clock, clearing mismatch and idle counters and faultCode; a compare result in that cycle SHALL be discarded.
REQ-027 clrFault outside FAULT SHALL have no effect.
REQ-028 relayCtrl SHALL equal RELAY_POL in RUN and SUSPECT, ~RELAY_POL in IDLE and FAULT, registered.
REQ-029 switchCtrl SHALL toggle every TOGGLE_DIV clocks in RUN/SUSPECT and hold its value in IDLE/FAULT; divider restarts at 0 on entry to RUN from IDLE.
REQ-030 mismatchTotal SHALL increment on every mismatching compare, saturate at 255, clear only on reset.

Reset
REQ-031 While rst=0: state IDLE, relayCtrl=~RELAY_POL, switchCtrl=0, fault=0, faultCode=0, mismatchTotal=0, all counters and capture registers 0.
REQ-032 Reset assertion mid-compare SHALL discard the pending result; first compare after release SHALL be judged from IDLE.

Verification
REQ-033 Reset release, busValid with busA=busB=16'h1234 -> RUN 2 clocks after strobe, relayCtrl=1, switchCtrl toggles every 4 clocks.
REQ-034 In RUN, 3 consecutive strobes with busA=16'h0001, busB=16'h0000 -> fault=1, faultCode=1, relayCtrl=0, switchCtrl frozen, mismatchTotal=3.
REQ-035 In RUN, 2 mismatches then 1 match -> RUN, no fault, mismatchTotal=2.
REQ-036 In RUN, no busValid for 255 clocks -> fault=1, faultCode=2; clrFault pulse -> IDLE, faultCode=0, mismatchTotal unchanged.
REQ-037 rst asserted in SUSPECT with pending strobe -> all outputs at reset values immediately; after release, one matching strobe -> RUN.
REQ-038 300 mismatching strobes interleaved with matches -> mismatchTotal saturates at 255.
